// File: rtl/attn_out_tile_sched.sv
// Sequences the 4x4 GEMM engine over A row-tiles: loads A rows, starts the engine, remaps results to output SRAM.
// Result writes lag gemm_out_valid by one cycle; no backpressure, commands accepted only while idle.
module attn_out_tile_sched #(
    parameter int A_ADDR_W   = 10,
    parameter int O_ADDR_W   = 12,
    parameter int TILE_W     = 8,
    parameter int A_READ_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [TILE_W-1:0]   cmd_num_tiles,
    input  logic [A_ADDR_W-1:0] cmd_a_base,
    input  logic [O_ADDR_W-1:0] cmd_o_base,
    output logic                a_rd_en,
    output logic [A_ADDR_W-1:0] a_rd_addr,
    input  logic [127:0]        a_rd_data,
    output logic                gemm_start,
    output logic [511:0]        gemm_A,
    input  logic                gemm_out_valid,
    input  logic [1:0]          gemm_out_row,
    input  logic [4:0]          gemm_out_group,
    input  logic [127:0]        gemm_out_data,
    input  logic                gemm_done,
    output logic                o_wr_en,
    output logic [O_ADDR_W-1:0] o_wr_addr,
    output logic [127:0]        o_wr_data,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_WAIT_A, S_START, S_RUN, S_FIN
    } state_t;

    state_t                state;
    logic [TILE_W-1:0]     num_tiles;
    logic [TILE_W-1:0]     tile;
    logic [A_ADDR_W-1:0]   a_base;
    logic [O_ADDR_W-1:0]   o_base;
    logic [1:0]            ld_k;
    logic [A_READ_LAT-1:0] pipe_vld;
    logic [1:0]            pipe_row [A_READ_LAT];
    logic [8:0]            res_cnt;
    logic [8:0]            res_cnt_nxt;
    logic [TILE_W-1:0]     tile_nxt;

    assign cmd_ready   = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign res_cnt_nxt = res_cnt + {8'd0, gemm_out_valid};
    assign tile_nxt    = tile + TILE_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            num_tiles  <= '0;
            tile       <= '0;
            a_base     <= '0;
            o_base     <= '0;
            ld_k       <= '0;
            pipe_vld   <= '0;
            for (int i = 0; i < A_READ_LAT; i++) pipe_row[i] <= '0;
            res_cnt    <= '0;
            a_rd_en    <= 1'b0;
            a_rd_addr  <= '0;
            gemm_start <= 1'b0;
            gemm_A     <= '0;
            o_wr_en    <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            gemm_start <= 1'b0;
            done       <= 1'b0;
            o_wr_en    <= 1'b0;

            // Tag each issued read with its row index so the returning word lands in the right slice.
            pipe_vld[0] <= a_rd_en;
            pipe_row[0] <= ld_k;
            for (int i = 1; i < A_READ_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_row[i] <= pipe_row[i-1];
            end
            if (pipe_vld[A_READ_LAT-1])
                gemm_A[{pipe_row[A_READ_LAT-1], 7'd0} +: 128] <= a_rd_data;

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        num_tiles <= cmd_num_tiles;
                        a_base    <= cmd_a_base;
                        o_base    <= cmd_o_base;
                        tile      <= '0;
                        err       <= 1'b0;
                        if (cmd_num_tiles == '0) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_LOAD_A;
                            a_rd_en   <= 1'b1;
                            a_rd_addr <= cmd_a_base;
                            ld_k      <= '0;
                        end
                    end
                end
                S_LOAD_A: begin
                    if (ld_k == 2'd3) begin
                        a_rd_en <= 1'b0;
                        state   <= S_WAIT_A;
                    end else begin
                        ld_k      <= ld_k + 2'd1;
                        a_rd_addr <= a_rd_addr + A_ADDR_W'(1);
                    end
                end
                S_WAIT_A: begin
                    if (pipe_vld[A_READ_LAT-1] && pipe_row[A_READ_LAT-1] == 2'd3) begin
                        state      <= S_START;
                        gemm_start <= 1'b1;
                    end
                end
                S_START: begin
                    state   <= S_RUN;
                    res_cnt <= '0;
                end
                S_RUN: begin
                    // {tile,row,group} is exactly (4*tile+row)*32+group.
                    if (gemm_out_valid) begin
                        o_wr_en   <= 1'b1;
                        o_wr_data <= gemm_out_data;
                        o_wr_addr <= o_base + O_ADDR_W'({tile, gemm_out_row, gemm_out_group});
                    end
                    res_cnt <= res_cnt_nxt;
                    if (gemm_done) begin
                        if (res_cnt_nxt != 9'd128) err <= 1'b1;
                        if (tile_nxt == num_tiles) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            tile      <= tile_nxt;
                            state     <= S_LOAD_A;
                            a_rd_en   <= 1'b1;
                            a_rd_addr <= a_base + A_ADDR_W'({tile_nxt, 2'b00});
                            ld_k      <= '0;
                        end
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_attn_out_tile_sched.sv
// Scoreboard bench: reference expectations are queued per command, monitors pop and compare on DUT activity.
`timescale 1ns/1ps
module tb_attn_out_tile_sched;
    localparam int AW = 10;
    localparam int OW = 12;
    localparam int TW = 8;

    typedef struct packed {
        logic [OW-1:0] addr;
        logic [127:0]  data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid, cmd_ready;
    logic [TW-1:0] cmd_num_tiles;
    logic [AW-1:0] cmd_a_base;
    logic [OW-1:0] cmd_o_base;
    logic          a_rd_en;
    logic [AW-1:0] a_rd_addr;
    logic [127:0]  a_rd_data;
    logic          gemm_start;
    logic [511:0]  gemm_A;
    logic          gemm_out_valid;
    logic [1:0]    gemm_out_row;
    logic [4:0]    gemm_out_group;
    logic [127:0]  gemm_out_data;
    logic          gemm_done;
    logic          o_wr_en;
    logic [OW-1:0] o_wr_addr;
    logic [127:0]  o_wr_data;
    logic          busy, done, err;

    always #5 clk = ~clk;

    attn_out_tile_sched dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_tiles(cmd_num_tiles),
        .cmd_a_base(cmd_a_base), .cmd_o_base(cmd_o_base),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
        .gemm_start(gemm_start), .gemm_A(gemm_A),
        .gemm_out_valid(gemm_out_valid), .gemm_out_row(gemm_out_row),
        .gemm_out_group(gemm_out_group), .gemm_out_data(gemm_out_data), .gemm_done(gemm_done),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .busy(busy), .done(done), .err(err)
    );

    int n_tests = 0, n_fail = 0;
    int rd_cnt = 0, start_cnt = 0, wr_cnt = 0, done_cnt = 0;
    logic [AW-1:0]  rd_q[$];
    logic [511:0]   tile_q[$];
    wr_t            wr_q[$];
    logic           err_q[$];
    logic [127:0]   a_mem [1024];
    logic [127:0]   a_p0, a_p1;
    int             eng_nv = 128;
    bit             eng_coinc = 0;
    bit             eng_busy = 0;
    logic [511:0]   eng_A, last_A;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Stand-in for the engine's math: any function of the received A row that the reference can recompute.
    function automatic logic [127:0] hsh(input logic [511:0] a, input int r, input int g);
        return a[128*r +: 128] ^ {4{32'(g * 97 + r * 13 + 1)}};
    endfunction

    // A SRAM with a fixed two-cycle read pipeline.
    always @(posedge clk) begin
        a_p0 <= a_rd_en ? a_mem[a_rd_addr] : {4{32'hBAD0_BAD0}};
        a_p1 <= a_p0;
    end
    assign a_rd_data = a_p1;

    task automatic run_engine();
        int  i = 0;
        bit  ab = 0;
        eng_busy = 1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        while (i < eng_nv && !ab) begin
            if (!rst_n) begin
                ab = 1;
                gemm_out_valid = 0;
                gemm_done = 0;
            end else if ($urandom_range(0, 3) != 0) begin
                gemm_out_valid = 1;
                gemm_out_row   = 2'(i / 32);
                gemm_out_group = 5'(i % 32);
                gemm_out_data  = hsh(eng_A, i / 32, i % 32);
                gemm_done      = eng_coinc && (i == eng_nv - 1);
                i++;
            end else begin
                gemm_out_valid = 0;
                gemm_done = 0;
            end
            @(negedge clk);
        end
        gemm_out_valid = 0;
        if (!ab && !eng_coinc && rst_n) begin
            gemm_done = 1;
            @(negedge clk);
        end
        gemm_done = 0;
        eng_busy = 0;
    endtask

    initial begin : engine
        gemm_out_valid = 0; gemm_done = 0;
        gemm_out_row = '0; gemm_out_group = '0; gemm_out_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n && gemm_start) begin
                eng_A = gemm_A;
                run_engine();
            end
        end
    end

    initial begin : monitor
        wr_t w;
        forever begin
            @(posedge clk); #1;
            if (rst_n) begin
                if (a_rd_en) begin
                    rd_cnt++;
                    if (rd_q.size() == 0) flag("a_rd_unexpected");
                    else chk("a_rd_addr", a_rd_addr, rd_q.pop_front());
                end
                if (gemm_start) begin
                    start_cnt++;
                    if (tile_q.size() == 0) flag("gemm_start_unexpected");
                    else begin
                        last_A = tile_q.pop_front();
                        chk("gemm_A_at_start", gemm_A, last_A);
                    end
                end
                if (gemm_done) chk("gemm_A_held_to_done", gemm_A, last_A);
                if (o_wr_en) begin
                    wr_cnt++;
                    if (wr_q.size() == 0) flag("o_wr_unexpected");
                    else begin
                        w = wr_q.pop_front();
                        chk("o_wr_addr", o_wr_addr, w.addr);
                        chk("o_wr_data", o_wr_data, w.data);
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (err_q.size() == 0) flag("done_unexpected");
                    else chk("err_at_done", err, err_q.pop_front());
                end
            end
        end
    end

    // Reference: tile t reads A rows a_base+4t+k; result (r,g) goes to o_base+(4t+r)*32+g.
    task automatic expect_cmd(input int nt, input int ab, input int ob, input int nv);
        logic [511:0]  tl;
        logic [AW-1:0] ai;
        wr_t           w;
        for (int t = 0; t < nt; t++) begin
            for (int k = 0; k < 4; k++) begin
                ai = AW'(ab + 4 * t + k);
                rd_q.push_back(ai);
                tl[128*k +: 128] = a_mem[ai];
            end
            tile_q.push_back(tl);
            for (int i = 0; i < nv; i++) begin
                w.addr = OW'(ob + (4 * t + i / 32) * 32 + i % 32);
                w.data = hsh(tl, i / 32, i % 32);
                wr_q.push_back(w);
            end
        end
        err_q.push_back(nt != 0 && nv != 128);
    endtask

    task automatic issue_cmd(input int nt, input int ab, input int ob);
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1; cmd_num_tiles = TW'(nt); cmd_a_base = AW'(ab); cmd_o_base = OW'(ob);
        @(negedge clk);
        chk("cmd_ready_after_accept", cmd_ready, 1'b0);
        chk("busy_after_accept", busy, 1'b1);
        chk("err_cleared_on_accept", err, 1'b0);
        chk("done_after_accept", done, nt == 0);
        if (nt == 0) begin
            cmd_valid = 0;
            @(negedge clk);
            chk("zero_tiles_ready_back", cmd_ready, 1'b1);
            chk("zero_tiles_done_single", done, 1'b0);
        end else begin
            // Held-high junk command while busy must be ignored.
            cmd_num_tiles = 8'hFF; cmd_a_base = '1; cmd_o_base = '1;
            repeat (4) @(negedge clk);
            cmd_valid = 0;
        end
    endtask

    task automatic run_cmd(input int nt, input int ab, input int ob, input int nv, input bit coinc);
        int rd0, st0, wr0, dn0;
        bit got;
        eng_nv = nv; eng_coinc = coinc;
        expect_cmd(nt, ab, ob, nv);
        rd0 = rd_cnt; st0 = start_cnt; wr0 = wr_cnt; dn0 = done_cnt;
        issue_cmd(nt, ab, ob);
        got = 0;
        for (int c = 0; c < 1000 * (nt + 1) && !got; c++) begin
            if (done_cnt > dn0) got = 1;
            else @(negedge clk);
        end
        if (!got) flag("done_timeout");
        repeat (2) @(negedge clk);
        chk("a_read_count", rd_cnt - rd0, 4 * nt);
        chk("gemm_start_count", start_cnt - st0, nt);
        chk("write_count", wr_cnt - wr0, nt * nv);
        chk("done_count", done_cnt - dn0, 1);
        chk("writes_left", wr_q.size(), 0);
    endtask

    task automatic check_reset_outs(input string name);
        chk(name, {cmd_ready, busy, a_rd_en, gemm_start, o_wr_en, done, err,
                   a_rd_addr, o_wr_addr, o_wr_data, gemm_A},
                  {1'b1, 6'b0, {(AW + OW + 128 + 512){1'b0}}});
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin : stim
        int wr0;
        bit got;
        cmd_valid = 0; cmd_num_tiles = '0; cmd_a_base = '0; cmd_o_base = '0;
        for (int i = 0; i < 1024; i++) a_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        #2 rst_n = 0;
        #1 check_reset_outs("reset_state");
        #17 rst_n = 1;

        run_cmd(1, 0, 0, 128, 0);
        run_cmd(3, 8, 100, 128, 0);
        run_cmd(0, 5, 5, 128, 0);
        run_cmd(1, 20, 40, 127, 0);
        run_cmd(1, 24, 60, 128, 0);
        run_cmd(2, 1020, 4096 - 16, 128, 1);
        for (int n = 0; n < 5; n++)
            run_cmd($urandom_range(0, 3), $urandom_range(0, 1023), $urandom_range(0, 4095),
                    ($urandom_range(0, 2) == 0) ? $urandom_range(124, 127) : 128,
                    1'($urandom_range(0, 1)));

        // Asynchronous reset in the middle of a result stream.
        eng_nv = 128; eng_coinc = 0;
        expect_cmd(2, 300, 2000, 128);
        wr0 = wr_cnt;
        issue_cmd(2, 300, 2000);
        got = 0;
        for (int c = 0; c < 2000 && !got; c++) begin
            if (wr_cnt - wr0 >= 40) got = 1;
            else @(negedge clk);
        end
        if (!got) flag("mid_run_write_timeout");
        #1 rst_n = 0;
        #1 check_reset_outs("reset_mid_run");
        rd_q.delete(); tile_q.delete(); wr_q.delete(); err_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1;
        got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            if (!eng_busy) got = 1;
            else @(negedge clk);
        end
        if (!got) flag("engine_abort_timeout");
        run_cmd(1, 40, 500, 128, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
